// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store unit: funct3 codes, LSU state
// encodings, response cause codes and the request-side decode helpers.
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ERR  = 3'd1,
      ST_REQ  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } lsu_state_e;

   function automatic logic f3_legal(input logic i_we, input logic [2:0] i_f3);
      logic v_ok;
      if (i_we) begin
         v_ok = (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W);
      end else begin
         v_ok = (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W) ||
                (i_f3 == F3_BU) || (i_f3 == F3_HU);
      end
      return v_ok;
   endfunction

   // funct3[1:0] encodes the access size for every legal load and store.
   function automatic logic f3_misaligned(input logic [2:0] i_f3, input logic [1:0] i_lo);
      logic v_mis;
      case (i_f3[1:0])
         2'b01:   v_mis = i_lo[0];
         2'b10:   v_mis = (i_lo != 2'b00);
         default: v_mis = 1'b0;
      endcase
      return v_mis;
   endfunction

   function automatic logic [3:0] be_gen(input logic [2:0] i_f3, input logic [1:0] i_lo);
      logic [3:0] v_be;
      case (i_f3[1:0])
         2'b00:   v_be = 4'b0001 << i_lo;
         2'b01:   v_be = 4'b0011 << i_lo;
         default: v_be = 4'b1111;
      endcase
      return v_be;
   endfunction

   function automatic logic [31:0] wdata_rep(input logic [2:0] i_f3, input logic [31:0] i_wdata);
      logic [31:0] v_w;
      case (i_f3[1:0])
         2'b00:   v_w = {4{i_wdata[7:0]}};
         2'b01:   v_w = {2{i_wdata[15:0]}};
         default: v_w = i_wdata;
      endcase
      return v_w;
   endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load data path: picks the byte/half lane addressed by addr[1:0] out of the
// raw memory word and sign- or zero-extends it according to funct3.
module rv32i_load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection from the byte offset
   always_comb begin
      w_byte = 8'h00;
      w_half = 16'h0000;
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
      if (i_addr_lo[1]) begin
         w_half = i_rdata[31:16];
      end else begin
         w_half = i_rdata[15:0];
      end
   end

   // Sign/zero extension to the full register width
   always_comb begin
      o_data = 32'h0000_0000;
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'h00_0000, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = {16'h0000, w_half};
         F3_W:    o_data = i_rdata;
         default: o_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: request decode, req/gnt/rvalid memory handshake and a
// one-cycle registered response to write-back. Optional watchdog: LSU_TIMEOUT_EN.
module rv32i_lsu
   import rv32i_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 64
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic [1:0]       rsp_cause,
   output logic             busy,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_e       r_state;
   lsu_state_e       w_next;
   logic             r_we;
   logic [2:0]       r_funct3;
   logic [1:0]       r_addr_lo;
   logic [1:0]       r_err_cause;
   logic [1:0]       w_dec_cause;
   logic             w_timeout;
   logic [WIDTH-1:0] w_load_data;

   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_rdata;
   logic             r_rsp_err;
   logic [1:0]       r_rsp_cause;
   logic             r_busy;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;
   logic [3:0]       r_mem_be;

   // Ready must read low for the whole reset period, hence the rst term.
   assign req_ready = (r_state == ST_IDLE) && !rst;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_cause = r_rsp_cause;
   assign busy      = r_busy;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;

   rv32i_load_align u_load_align (
      .i_rdata   (mem_rdata),
      .i_addr_lo (r_addr_lo),
      .i_funct3  (r_funct3),
      .o_data    (w_load_data)
   );

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 2);
   logic [7:0] r_cnt;

   // Watchdog: fires on the cycle whose increment would reach TIMEOUT_CYC-1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if ((r_state != ST_REQ) && (w_next == ST_REQ)) begin
         r_cnt <= 8'd0;
      end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
         r_cnt <= r_cnt + 8'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign w_timeout = (r_cnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state decode; illegal funct3 takes priority over misalignment
   always_comb begin
      w_next      = r_state;
      w_dec_cause = CAUSE_NONE;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (!f3_legal(req_we, req_funct3)) begin
                  w_next      = ST_ERR;
                  w_dec_cause = CAUSE_ILLEGAL;
               end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                  w_next      = ST_ERR;
                  w_dec_cause = CAUSE_MISALIGN;
               end else begin
                  w_next = ST_REQ;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ERR:  w_next = ST_IDLE;
         ST_REQ: begin
            if (mem_gnt && r_we) begin
               w_next = ST_DONE;
            end else if (w_timeout) begin
               w_next      = ST_ERR;
               w_dec_cause = CAUSE_TIMEOUT;
            end else if (mem_gnt) begin
               w_next = ST_WAIT;
            end else begin
               w_next = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               w_next = ST_DONE;
            end else if (w_timeout) begin
               w_next      = ST_ERR;
               w_dec_cause = CAUSE_TIMEOUT;
            end else begin
               w_next = ST_WAIT;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State register, request capture and memory-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_err_cause <= CAUSE_NONE;
         r_busy      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= 4'b0000;
      end else begin
         r_state   <= w_next;
         r_busy    <= (w_next != ST_IDLE);
         r_mem_req <= (w_next == ST_REQ);
         if ((r_state == ST_IDLE) && req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr_lo   <= req_addr[1:0];
            r_mem_we    <= req_we;
            r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
            r_mem_wdata <= wdata_rep(req_funct3, req_wdata);
            r_mem_be    <= be_gen(req_funct3, req_addr[1:0]);
         end else begin
            r_mem_we <= r_mem_we;
         end
         if (w_next == ST_ERR) begin
            r_err_cause <= w_dec_cause;
         end else begin
            r_err_cause <= r_err_cause;
         end
      end
   end

   // Response register: error responses leave ERR, good ones arrive with DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_cause <= CAUSE_NONE;
         r_rsp_rdata <= '0;
      end else if (r_state == ST_ERR) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= 1'b1;
         r_rsp_cause <= r_err_cause;
         r_rsp_rdata <= '0;
      end else if (w_next == ST_DONE) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= 1'b0;
         r_rsp_cause <= CAUSE_NONE;
         r_rsp_rdata <= r_we ? '0 : w_load_data;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_cause <= CAUSE_NONE;
         r_rsp_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed vector table, reset/timeout
// sequences and randomized ops checked against a behavioural model.
module tb_rv32i_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_cause;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rv32i_lsu #(.WIDTH(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_cause(rsp_cause), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gdly;
      int          rdly;
      logic        e_err;
      logic [1:0]  e_cause;
      logic [31:0] e_rdata;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: size from funct3, alignment by modulo, lanes by shifting.
   function automatic void model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata,
                                 output logic e_err, output logic [1:0] e_cause,
                                 output logic [31:0] e_rdata, output logic [3:0] e_be,
                                 output logic [31:0] e_wdata);
      int          sz;
      int          off;
      logic        legal;
      logic [63:0] v;
      logic [63:0] mask;
      sz  = 1 << int'(f3 % 4);
      off = int'(addr % 4);
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 != 3'd3) && (f3 < 3'd6);
      e_err = 1'b0; e_cause = 2'b00; e_rdata = 32'h0;
      if (!legal) begin
         e_err = 1'b1; e_cause = 2'b10;
      end else if ((addr % sz) != 0) begin
         e_err = 1'b1; e_cause = 2'b01;
      end
      e_be = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
      if (!we && !e_err) begin
         v    = 64'(rdata) >> (8 * off);
         mask = (64'd1 << (8 * sz)) - 64'd1;
         v    = v & mask;
         if ((f3 < 3'd4) && (sz < 4) && v[8*sz-1]) v = v | ~mask;
         e_rdata = v[31:0];
      end
   endfunction

   // One transaction; entered and left #1 after a rising edge.
   task automatic run_op(input vec_t v, input logic junk, input string tag);
      int          gcyc;
      int          rvcyc;
      int          rspcyc;
      logic [31:0] e_addr;
      gcyc  = 1 + v.gdly;
      rvcyc = gcyc + 1 + v.rdly;
      if (v.e_err)   rspcyc = 2;
      else if (v.we) rspcyc = gcyc + 1;
      else           rspcyc = rvcyc + 1;
      e_addr = v.addr & 32'hFFFF_FFFC;
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      chk({tag, " ready"}, 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom); req_we = 1'($urandom);
      for (int k = 1; k <= rspcyc; k++) begin
         mem_gnt    = !v.e_err && (k == gcyc);
         mem_rvalid = (!v.e_err && !v.we && (k == rvcyc)) || (v.we && junk && (k <= gcyc));
         mem_rdata  = (k == rvcyc) ? v.rdata : $urandom;
         @(negedge clk);
         if (!v.e_err && (k <= gcyc)) begin
            chk({tag, " mem_req"}, 64'(mem_req), 64'd1);
            chk({tag, " mem_addr"}, 64'(mem_addr), 64'(e_addr));
            chk({tag, " mem_be"}, 64'(mem_be), 64'(v.e_be));
            chk({tag, " mem_we"}, 64'(mem_we), 64'(v.we));
            if (v.we) chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(v.e_wdata));
         end else begin
            chk({tag, " mem_req"}, 64'(mem_req), 64'd0);
         end
         chk({tag, " busy"}, 64'(busy), 64'((k < rspcyc) || !v.e_err));
         if (k == rspcyc)
            chk({tag, " rsp"}, 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}),
                64'({1'b1, v.e_err, v.e_cause, v.e_rdata}));
         else
            chk({tag, " rsp"}, 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}), 64'd0);
         @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   vec_t tbl[15];
   vec_t rv;
   int   to_rsp;
   int   to_req_last;
   int   to_busy_last;

   initial begin
      tbl[0]  = '{1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 2'b00, 32'h0, 4'b1000, 32'hA5A5_A5A5};
      tbl[1]  = '{1'b0, 3'b000, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0, 2'b00, 32'hFFFF_FFF4, 4'b0100, 32'h0};
      tbl[2]  = '{1'b0, 3'b100, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0, 2'b00, 32'h0000_00F4, 4'b0100, 32'h0};
      tbl[3]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h12F4_5678, 0, 0, 1'b0, 2'b00, 32'h0000_12F4, 4'b1100, 32'h0};
      tbl[4]  = '{1'b0, 3'b010, 32'h206, 32'h0, 32'h0, 0, 0, 1'b1, 2'b01, 32'h0, 4'b1111, 32'h0};
      tbl[5]  = '{1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0, 1'b1, 2'b10, 32'h0, 4'b1111, 32'h0};
      tbl[6]  = '{1'b0, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 3, 2, 1'b0, 2'b00, 32'hDEAD_BEEF, 4'b1111, 32'h0};
      tbl[7]  = '{1'b1, 3'b001, 32'h10A, 32'h1234_ABCD, 32'h0, 1, 0, 1'b0, 2'b00, 32'h0, 4'b1100, 32'hABCD_ABCD};
      tbl[8]  = '{1'b1, 3'b100, 32'h010, 32'h1, 32'h0, 0, 0, 1'b1, 2'b10, 32'h0, 4'b0001, 32'h0};
      tbl[9]  = '{1'b0, 3'b001, 32'h0FE, 32'h0, 32'h8001_7777, 1, 1, 1'b0, 2'b00, 32'hFFFF_8001, 4'b1100, 32'h0};
      tbl[10] = '{1'b1, 3'b010, 32'h1001, 32'h5, 32'h0, 0, 0, 1'b1, 2'b01, 32'h0, 4'b1111, 32'h0};
      tbl[11] = '{1'b1, 3'b001, 32'h101, 32'h5, 32'h0, 0, 0, 1'b1, 2'b01, 32'h0, 4'b0011, 32'h0};
      tbl[12] = '{1'b0, 3'b110, 32'h001, 32'h0, 32'h0, 0, 0, 1'b1, 2'b10, 32'h0, 4'b0011, 32'h0};
      tbl[13] = '{1'b1, 3'b010, 32'h2000, 32'hCAFE_F00D, 32'h0, 2, 0, 1'b0, 2'b00, 32'h0, 4'b1111, 32'hCAFE_F00D};
      tbl[14] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h7F00_0000, 0, 3, 1'b0, 2'b00, 32'h0000_007F, 4'b1000, 32'h0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst rsp", 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}), 64'd0);
      chk("rst mem", 64'({mem_req, mem_we, mem_be, mem_wdata}), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;

      foreach (tbl[i]) run_op(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Reset while waiting for load data; the late rvalid must be dropped
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("rstw mem_req", 64'(mem_req), 64'd1);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("rstw busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstw ready in rst", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      @(negedge clk);
      chk("rstw ready", 64'(req_ready), 64'd1);
      chk("rstw idle", 64'({mem_req, busy, rsp_valid}), 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstw no rsp", 64'({rsp_valid, busy}), 64'd0);
         @(posedge clk); #1;
      end

      // Long grant stall: watchdog error when enabled, otherwise wait it out
`ifdef LSU_TIMEOUT_EN
      to_rsp = 9; to_req_last = 7; to_busy_last = 8;
`else
      to_rsp = 78; to_req_last = 75; to_busy_last = 78;
`endif
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_rdata = 32'h1357_2468;
      for (int k = 1; k <= 80; k++) begin
         mem_gnt    = (k == 75);
         mem_rvalid = (k == 77);
         @(negedge clk);
         chk("stall mem_req", 64'(mem_req), 64'(k <= to_req_last));
         chk("stall busy", 64'(busy), 64'(k <= to_busy_last));
         if (k == to_rsp) begin
`ifdef LSU_TIMEOUT_EN
            chk("stall rsp", 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}), 64'({1'b1, 1'b1, 2'b11, 32'h0}));
`else
            chk("stall rsp", 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}), 64'({1'b1, 1'b0, 2'b00, 32'h1357_2468}));
`endif
         end else begin
            chk("stall rsp", 64'({rsp_valid, rsp_err, rsp_cause, rsp_rdata}), 64'd0);
         end
         @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;

      // Randomized ops against the model
      for (int n = 0; n < 200; n++) begin
         rv.we    = 1'($urandom);
         rv.f3    = 3'($urandom_range(0, 7));
         rv.addr  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.gdly  = $urandom_range(0, 3);
         rv.rdly  = $urandom_range(0, 3);
         model(rv.we, rv.f3, rv.addr, rv.wdata, rv.rdata,
               rv.e_err, rv.e_cause, rv.e_rdata, rv.e_be, rv.e_wdata);
         run_op(rv, 1'($urandom), $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
